// File: rtl/alu_pool_scheduler.sv
// alu_pool_scheduler: registered oldest-issue-first allocator sharing NUM_ALUS
// ALUs among NUM_PORTS issue controllers, with a per-port hold watchdog.
module alu_pool_scheduler #(
    parameter int unsigned NUM_ALUS     = 4,
    parameter int unsigned NUM_PORTS    = 4,
    parameter int unsigned ID_WIDTH     = 16,
    parameter int unsigned HOLD_TIMEOUT = 64
) (
    input  logic                                                     clk,
    input  logic                                                     rst,
    input  logic [NUM_PORTS-1:0]                                     req,
    input  logic [NUM_PORTS*ID_WIDTH-1:0]                            req_issue_id,
    input  logic [NUM_PORTS-1:0]                                     release_lock,
    output logic [NUM_PORTS-1:0]                                     grant,
    output logic [NUM_PORTS*((NUM_ALUS > 1) ? $clog2(NUM_ALUS) : 1)-1:0] alloc_id,
    output logic [$clog2(NUM_ALUS+1)-1:0]                            free_count,
    output logic                                                     pool_busy,
    output logic [NUM_PORTS-1:0]                                     timeout_pulse
);

    localparam int unsigned AW      = (NUM_ALUS  > 1) ? $clog2(NUM_ALUS)  : 1;
    localparam int unsigned PW      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned CW      = $clog2(NUM_ALUS + 1);
    localparam int unsigned MX      = (NUM_PORTS > NUM_ALUS) ? NUM_PORTS : NUM_ALUS;
    localparam int unsigned RW      = $clog2(MX + 1);
    localparam int unsigned HW      = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
    localparam int unsigned TO_LAST = (HOLD_TIMEOUT > 0) ? HOLD_TIMEOUT - 1 : 0;
    localparam bit          WD_EN   = (HOLD_TIMEOUT > 0);

    // Registered pool state: per-ALU owner, per-port hold counter
    logic [NUM_ALUS-1:0] owner_valid;
    logic [PW-1:0]       owner_port [NUM_ALUS];
    logic [HW-1:0]       hold_cnt   [NUM_PORTS];

    // Arbitration results
    logic [NUM_PORTS-1:0] waiting;
    logic [NUM_PORTS-1:0] release_now;
    logic [NUM_PORTS-1:0] reclaim_now;
    logic [NUM_PORTS-1:0] drop_now;
    logic [ID_WIDTH-1:0]  port_id    [NUM_PORTS];
    logic [RW-1:0]        wait_rank  [NUM_PORTS];
    logic [RW-1:0]        free_rank  [NUM_ALUS];
    logic [NUM_PORTS-1:0] hit;
    logic [AW-1:0]        port_alu   [NUM_PORTS];
    logic [NUM_ALUS-1:0]  taken;
    logic [PW-1:0]        taken_port [NUM_ALUS];
    logic [NUM_ALUS-1:0]  next_valid;
    logic [CW-1:0]        next_free;
    logic [ID_WIDTH-1:0]  diff;

    // Age ranking of waiters, free-ALU ranking, rank matching and next pool state
    always_comb begin
        waiting     = '0;
        release_now = '0;
        reclaim_now = '0;
        drop_now    = '0;
        hit         = '0;
        taken       = '0;
        next_valid  = '0;
        next_free   = '0;
        diff        = '0;
        for (int p = 0; p < int'(NUM_PORTS); p++) begin
            port_id[p]   = req_issue_id[p*ID_WIDTH +: ID_WIDTH];
            wait_rank[p] = '0;
            port_alu[p]  = '0;
        end
        for (int a = 0; a < int'(NUM_ALUS); a++) begin
            free_rank[a]  = '0;
            taken_port[a] = '0;
        end

        for (int p = 0; p < int'(NUM_PORTS); p++) begin
            waiting[p]     = req[p] & ~grant[p];
            release_now[p] = grant[p] & release_lock[p];
            reclaim_now[p] = WD_EN && grant[p] && !release_lock[p]
                             && (hold_cnt[p] == HW'(TO_LAST));
            drop_now[p]    = release_now[p] | reclaim_now[p];
        end

        // rank = number of waiters strictly older (ties go to the lower port)
        for (int p = 0; p < int'(NUM_PORTS); p++) begin
            for (int q = 0; q < int'(NUM_PORTS); q++) begin
                if (q != p && waiting[p] && waiting[q]) begin
                    diff = port_id[q] - port_id[p];
                    if (diff[ID_WIDTH-1] || (diff == '0 && q < p))
                        wait_rank[p] = wait_rank[p] + RW'(1);
                end
            end
        end

        for (int a = 0; a < int'(NUM_ALUS); a++)
            for (int b = 0; b < a; b++)
                if (!owner_valid[b]) free_rank[a] = free_rank[a] + RW'(1);

        // k-th oldest waiter takes k-th free ALU; first claimant wins if ranks collide
        for (int a = 0; a < int'(NUM_ALUS); a++) begin
            if (!owner_valid[a]) begin
                for (int p = 0; p < int'(NUM_PORTS); p++) begin
                    if (waiting[p] && !taken[a] && !hit[p] && wait_rank[p] == free_rank[a]) begin
                        taken[a]      = 1'b1;
                        taken_port[a] = PW'(p);
                        hit[p]        = 1'b1;
                        port_alu[p]   = AW'(a);
                    end
                end
            end
        end

        for (int a = 0; a < int'(NUM_ALUS); a++) begin
            next_valid[a] = (owner_valid[a] && !drop_now[owner_port[a]]) || taken[a];
            if (!next_valid[a]) next_free = next_free + CW'(1);
        end
    end

    // Pool, grant, watchdog and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_valid   <= '0;
            grant         <= '0;
            alloc_id      <= '0;
            timeout_pulse <= '0;
            free_count    <= CW'(NUM_ALUS);
            pool_busy     <= 1'b0;
            for (int a = 0; a < int'(NUM_ALUS); a++) owner_port[a] <= '0;
            for (int p = 0; p < int'(NUM_PORTS); p++) hold_cnt[p] <= '0;
        end else begin
            owner_valid   <= next_valid;
            free_count    <= next_free;
            pool_busy     <= (next_free == '0);
            timeout_pulse <= reclaim_now;
            for (int a = 0; a < int'(NUM_ALUS); a++)
                if (taken[a]) owner_port[a] <= taken_port[a];
            for (int p = 0; p < int'(NUM_PORTS); p++) begin
                if (drop_now[p]) begin
                    grant[p]                <= 1'b0;
                    alloc_id[p*AW +: AW]    <= '0;
                    hold_cnt[p]             <= '0;
                end else if (hit[p]) begin
                    grant[p]                <= 1'b1;
                    alloc_id[p*AW +: AW]    <= port_alu[p];
                    hold_cnt[p]             <= '0;
                end else if (grant[p] && WD_EN) begin
                    hold_cnt[p]             <= hold_cnt[p] + HW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_pool_scheduler.sv
// tb_alu_pool_scheduler: scoreboard bench with a queue/sort based reference model.
module tb_alu_pool_scheduler;

    localparam int NA  = 4;
    localparam int NP  = 6;
    localparam int IDW = 16;
    localparam int HT  = 8;
    localparam int AW  = 2;
    localparam int CW  = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic [NP-1:0]      req;
    logic [NP*IDW-1:0]  req_issue_id;
    logic [NP-1:0]      release_lock;
    logic [NP-1:0]      grant;
    logic [NP*AW-1:0]   alloc_id;
    logic [CW-1:0]      free_count;
    logic               pool_busy;
    logic [NP-1:0]      timeout_pulse;

    alu_pool_scheduler #(.NUM_ALUS(NA), .NUM_PORTS(NP), .ID_WIDTH(IDW), .HOLD_TIMEOUT(HT)) dut (
        .clk(clk), .rst(rst), .req(req), .req_issue_id(req_issue_id),
        .release_lock(release_lock), .grant(grant), .alloc_id(alloc_id),
        .free_count(free_count), .pool_busy(pool_busy), .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NP-1:0]    grant;
        logic [NP*AW-1:0] alloc;
        logic [CW-1:0]    fc;
        logic             busy;
        logic [NP-1:0]    pulse;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state: ALU owned by each port (-1 none) and cycles held so far
    int own  [NP];
    int held [NP];

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endfunction

    function automatic logic [IDW-1:0] id_of(input int p);
        return req_issue_id[p*IDW +: IDW];
    endfunction

    function automatic bit older(input int a, input int b);
        logic [IDW-1:0] d;
        d = id_of(a) - id_of(b);
        return d[IDW-1];
    endfunction

    function automatic int alloc_of(input int p);
        return int'(alloc_id[p*AW +: AW]);
    endfunction

    task automatic set_id(input int p, input int v);
        req_issue_id[p*IDW +: IDW] = IDW'(v);
    endtask

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            own[p]  = -1;
            held[p] = 0;
        end
    endtask

    // One clock of the reference model using the inputs currently driven
    task automatic model_step(output exp_t e);
        int waiters[$];
        int frees[$];
        bit busy_alu [NA];
        bit pulse    [NP];
        int nfree;
        for (int a = 0; a < NA; a++) busy_alu[a] = 1'b0;
        for (int p = 0; p < NP; p++) if (own[p] >= 0) busy_alu[own[p]] = 1'b1;
        for (int a = 0; a < NA; a++) if (!busy_alu[a]) frees.push_back(a);
        for (int p = 0; p < NP; p++) begin
            if (req[p] && own[p] < 0) begin
                int pos;
                pos = waiters.size();
                for (int k = 0; k < waiters.size(); k++)
                    if (older(p, waiters[k])) begin pos = k; break; end
                waiters.insert(pos, p);
            end
        end
        for (int p = 0; p < NP; p++) begin
            pulse[p] = 1'b0;
            if (own[p] >= 0) begin
                if (release_lock[p]) own[p] = -1;
                else if (held[p] + 1 == HT) begin own[p] = -1; pulse[p] = 1'b1; end
                else held[p]++;
            end
        end
        for (int k = 0; k < waiters.size() && k < frees.size(); k++) begin
            own[waiters[k]]  = frees[k];
            held[waiters[k]] = 0;
        end
        e = '0;
        nfree = NA;
        for (int p = 0; p < NP; p++) begin
            e.pulse[p] = pulse[p];
            if (own[p] >= 0) begin
                e.grant[p] = 1'b1;
                e.alloc[p*AW +: AW] = AW'(own[p]);
                nfree--;
            end
        end
        e.fc   = CW'(nfree);
        e.busy = (nfree == 0);
    endtask

    // Called at posedge+1 with inputs set; returns at the following posedge+1
    task automatic cycle();
        exp_t e;
        model_step(e);
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    // Monitor: compares every registered output against the scoreboard entry
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("grant",         64'(grant),         64'(mon_e.grant));
            check("alloc_id",      64'(alloc_id),      64'(mon_e.alloc));
            check("free_count",    64'(free_count),    64'(mon_e.fc));
            check("pool_busy",     64'(pool_busy),     64'(mon_e.busy));
            check("timeout_pulse", 64'(timeout_pulse), 64'(mon_e.pulse));
        end
    end

    task automatic clear_all();
        req = '0;
        release_lock = '1;
        cycle();
        release_lock = '0;
        cycle();
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        release_lock = '0;
        req_issue_id = '0;
        model_reset();
        #12;
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_alloc", 64'(alloc_id), 64'd0);
        check("rst_free", 64'(free_count), 64'd4);
        check("rst_busy", 64'(pool_busy), 64'd0);
        check("rst_pulse", 64'(timeout_pulse), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single grant and release
        req[0] = 1'b1; set_id(0, 5);
        cycle();
        check("single_grant", 64'(grant[0]), 64'd1);
        check("single_alloc", 64'(alloc_of(0)), 64'd0);
        check("single_free", 64'(free_count), 64'd3);
        req[0] = 1'b0; release_lock[0] = 1'b1;
        cycle();
        release_lock = '0;
        check("single_rel_grant", 64'(grant[0]), 64'd0);
        check("single_rel_free", 64'(free_count), 64'd4);

        // Age order with two ALUs left
        req[4] = 1'b1; req[5] = 1'b1; set_id(4, 100); set_id(5, 101);
        cycle();
        req = '0;
        req[3:0] = 4'hF; set_id(0, 9); set_id(1, 3); set_id(2, 7); set_id(3, 3);
        cycle();
        check("age_grant", 64'(grant), 64'b111010);
        check("age_alloc1", 64'(alloc_of(1)), 64'd2);
        check("age_alloc3", 64'(alloc_of(3)), 64'd3);
        check("age_busy", 64'(pool_busy), 64'd1);
        cycle();
        check("age_wait", 64'(grant[2]) | 64'(grant[0]), 64'd0);
        clear_all();

        // Wrap-around age, then release-to-reuse gap
        req[5:3] = 3'b111; set_id(3, 1); set_id(4, 2); set_id(5, 3);
        cycle();
        req = '0;
        req[0] = 1'b1; req[1] = 1'b1; set_id(0, 16'h0002); set_id(1, 16'hFFFE);
        cycle();
        check("wrap_grant1", 64'(grant[1]), 64'd1);
        check("wrap_alloc1", 64'(alloc_of(1)), 64'd3);
        check("wrap_grant0", 64'(grant[0]), 64'd0);
        req[1] = 1'b0; release_lock[1] = 1'b1;
        cycle();
        release_lock = '0;
        check("gap_t1", 64'(grant[0]), 64'd0);
        cycle();
        check("gap_t2_grant", 64'(grant[0]), 64'd1);
        check("gap_t2_alloc", 64'(alloc_of(0)), 64'd3);
        clear_all();

        // Watchdog reclaim
        req[2] = 1'b1; set_id(2, 50);
        cycle();
        req = '0;
        for (int i = 0; i < HT - 1; i++) cycle();
        check("wd_still_held", 64'(grant[2]), 64'd1);
        cycle();
        check("wd_grant", 64'(grant[2]), 64'd0);
        check("wd_pulse", 64'(timeout_pulse[2]), 64'd1);
        check("wd_free", 64'(free_count), 64'd4);
        cycle();
        check("wd_pulse_once", 64'(timeout_pulse), 64'd0);

        // Release in the last allowed cycle beats the watchdog
        req[2] = 1'b1;
        cycle();
        req = '0;
        for (int i = 0; i < HT - 1; i++) cycle();
        release_lock[2] = 1'b1;
        cycle();
        release_lock = '0;
        check("wd_rel_grant", 64'(grant[2]), 64'd0);
        check("wd_rel_pulse", 64'(timeout_pulse), 64'd0);

        // Randomized traffic with IDs spread across the 16-bit wrap point
        for (int c = 0; c < 1500; c++) begin
            for (int p = 0; p < NP; p++) begin
                req[p] = ($urandom_range(0, 99) < 60);
                release_lock[p] = ($urandom_range(0, 99) < 25);
                set_id(p, 16'hFF00 + int'($urandom_range(0, 4000)));
            end
            cycle();
        end

        // Async reset mid-hold
        clear_all();
        req[2:0] = 3'b111; set_id(0, 10); set_id(1, 11); set_id(2, 12);
        cycle();
        check("ar_held", 64'(grant), 64'b000111);
        req = '0;
        #6;
        rst = 1'b1;
        #1;
        check("ar_grant", 64'(grant), 64'd0);
        check("ar_free", 64'(free_count), 64'd4);
        check("ar_alloc", 64'(alloc_id), 64'd0);
        check("ar_pulse", 64'(timeout_pulse), 64'd0);
        rst = 1'b0;
        model_reset();
        req[0] = 1'b1;
        cycle();
        check("ar_regrant", 64'(grant[0]), 64'd1);
        req = '0;
        cycle();

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        #6;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
